// File: rtl/div_pkg.sv
// div_pkg: shared state encodings, default width and counter sizing for the restoring divider
package div_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int DEF_WIDTH = 4;
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/div_add_sub_stage.sv
// div_add_sub_stage: W-bit add (m=0) or subtract (m=1) via inverted b and carry-in m
module div_add_sub_stage #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         m,
  output logic [W-1:0] s
);
  assign s = a + (b ^ {W{m}}) + {{(W-1){1'b0}}, m};
endmodule

// File: rtl/four_bit_restoring_divider.sv
// four_bit_restoring_divider: shift-subtract-restore divider, one quotient bit per clock; SIGNED_DIV_EN adds two's-complement operands
module four_bit_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             V,
  output logic             busy,
  output logic             done
);
  localparam int CNT_W = cnt_width(WIDTH);
  logic [1:0] state;
  logic [WIDTH-1:0] a, q, m, a_next, q_next, rest, dd_mag, dv_mag, q_fin, r_fin;
  logic [WIDTH:0] sh, diff;
  logic [CNT_W-1:0] cnt;
  logic accept, last, zero_div;
  assign accept = state == IDLE && start;
  assign last = state == RUN && cnt == CNT_W'(1);
  assign zero_div = divisor == '0;
  assign sh = {a, q[WIDTH-1]};
  div_add_sub_stage #(.W(WIDTH + 1)) u_sub (
    .a(sh),
    .b({1'b0, m}),
    .m(1'b1),
    .s(diff)
  );
  // The partial remainder always fits in WIDTH bits, so restore needs no sign bit
  div_add_sub_stage #(.W(WIDTH)) u_restore (
    .a(diff[WIDTH-1:0]),
    .b(m),
    .m(1'b0),
    .s(rest)
  );
  assign a_next = diff[WIDTH] ? rest : diff[WIDTH-1:0];
  assign q_next = {q[WIDTH-2:0], ~diff[WIDTH]};
  assign busy = state != IDLE;
  assign done = state == DONE;
`ifdef SIGNED_DIV_EN
  logic neg_q, neg_r, ovf;
  assign dd_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign dv_mag = divisor[WIDTH-1] ? -divisor : divisor;
  assign q_fin = neg_q ? -q_next : q_next;
  assign r_fin = neg_r ? -a_next : a_next;
  // Capture result signs and the most-negative/-1 overflow at load; publish V with the result
  always_ff @(posedge clk)
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      ovf <= 1'b0;
      V <= 1'b0;
    end else if (accept) begin
      neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r <= dividend[WIDTH-1];
      ovf <= dividend == {1'b1, {(WIDTH-1){1'b0}}} && &divisor;
      V <= 1'b0;
    end else if (last) V <= ovf;
`else
  assign dd_mag = dividend;
  assign dv_mag = divisor;
  assign q_fin = q_next;
  assign r_fin = a_next;
  assign V = 1'b0;
`endif
  // FSM, iteration datapath and result registers
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      a <= '0;
      q <= '0;
      m <= '0;
      cnt <= '0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      state <= zero_div ? DONE : RUN;
      a <= '0;
      q <= dd_mag;
      m <= dv_mag;
      cnt <= CNT_W'(WIDTH);
      quotient <= zero_div ? {WIDTH{1'b1}} : '0;
      remainder <= zero_div ? dividend : '0;
      div_by_zero <= zero_div;
    end else if (state == RUN) begin
      a <= a_next;
      q <= q_next;
      cnt <= cnt - CNT_W'(1);
      if (last) begin
        state <= DONE;
        quotient <= q_fin;
        remainder <= r_fin;
      end
    end else state <= IDLE;
endmodule

// File: tb/tb_four_bit_restoring_divider.sv
// tb_four_bit_restoring_divider: scoreboard bench; stimulus pushes expected results, a negedge monitor pops on done
module tb_four_bit_restoring_divider;
  typedef struct packed {
    logic [3:0] q;
    logic [3:0] r;
    logic       z;
    logic       v;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [3:0] dividend = '0, divisor = '0;
  logic [3:0] quotient, remainder;
  logic div_by_zero, V, busy, done;
  exp_t sb[$];
  int compared = 0, mismatched = 0, ndone = 0;
  logic done_q = 1'b0;

  four_bit_restoring_divider #(.WIDTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero),
    .V(V),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      ndone++;
      chk("done_width", {30'd0, done_q, done}, 32'd1);
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL done_unexpected: got done=1 expected no pending operation");
      end else begin
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", div_by_zero, e.z);
        chk("V", V, e.v);
      end
    end
    done_q = done;
  end

  task automatic launch(input logic [3:0] dd, input logic [3:0] dv);
    dividend = dd;
    divisor = dv;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int lat);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
      chk({name, "_busy"}, busy, 1);
    end while (done !== 1'b1 && n < 30);
    chk({name, "_latency"}, n, lat);
    @(negedge clk);
    chk({name, "_idle"}, {busy, done}, 0);
  endtask

  task automatic op(input string name, input logic [3:0] dd, input logic [3:0] dv,
                    input logic [3:0] eq, input logic [3:0] er, input logic ez, input logic ev,
                    input int lat);
    exp_t e;
    e = {eq, er, ez, ev};
    sb.push_back(e);
    launch(dd, dv);
    wait_done(name, lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end in time");
    $fatal(1);
  end

  initial begin
    int n0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    chk("rst_V", V, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
`ifdef SIGNED_DIV_EN
    op("s_13_3", 4'd13, 4'd3, 4'hF, 4'd0, 1'b0, 1'b0, 5);
`else
    op("u_13_3", 4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 1'b0, 5);
`endif
    op("dbz_7_0", 4'd7, 4'd0, 4'hF, 4'd7, 1'b1, 1'b0, 1);
    op("u_15_1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 1'b0, 5);
    sb.push_back({4'd0, 4'd2, 1'b0, 1'b0});
    launch(4'd2, 4'd9);
    @(negedge clk);
    @(negedge clk);
    n0 = ndone;
    dividend = 4'd15;
    divisor = 4'd1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(negedge clk);
    chk("ign_done_count", ndone - n0, 1);
    chk("ign_hold_quotient", quotient, 0);
    chk("ign_hold_remainder", remainder, 2);
    chk("ign_busy", busy, 0);
    launch(4'd14, 4'd5);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    chk("abort_dbz", div_by_zero, 0);
    chk("abort_V", V, 0);
`ifdef SIGNED_DIV_EN
    op("s_9_2", 4'd9, 4'd2, 4'b1101, 4'b1111, 1'b0, 1'b0, 5);
    op("s_m7_2", 4'b1001, 4'd2, 4'b1101, 4'b1111, 1'b0, 1'b0, 5);
    op("s_m8_m1", 4'b1000, 4'b1111, 4'b1000, 4'd0, 1'b0, 1'b1, 5);
    op("s_7_m2", 4'd7, 4'b1110, 4'b1101, 4'd1, 1'b0, 1'b0, 5);
    op("s_m8_0", 4'b1000, 4'd0, 4'hF, 4'b1000, 1'b1, 1'b0, 1);
`else
    op("u_9_2", 4'd9, 4'd2, 4'd4, 4'd1, 1'b0, 1'b0, 5);
    for (int a = 0; a < 16; a++)
      for (int b = 1; b < 16; b++)
        op("sweep", 4'(a), 4'(b), 4'(a / b), 4'(a % b), 1'b0, 1'b0, 5);
`endif
    repeat (3) @(negedge clk);
    chk("queue_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
